// File: rtl/c2h_stream_arbiter_pkg.sv
// Shared definitions for the C2H stream arbiter and the ADC data producers:
// FSM state encoding, packet-size constant and beat counter width helper.
package c2h_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_e;

    // Must match the host DMA block size in words; the producers frame packets with it too.
    localparam int C2H_MAX_PKT_WORDS = 2048;

    function automatic int beat_cnt_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/c2h_stream_arbiter_axis_skid_buffer.sv
// Two-entry AXI4-Stream skid buffer with fully registered outputs; only
// present when C2H_ARB_SKID_EN is defined.
`ifdef C2H_ARB_SKID_EN
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic             push_s;

    // Ready depends only on the skid slot, so the downstream ready never reaches the input.
    assign in_ready  = ~skid_valid_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    // Next-state for output and skid registers.
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        push_s       = in_valid & ~skid_valid_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (push_s) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (push_s) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // Buffer state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule
`endif

// File: rtl/c2h_stream_arbiter.sv
// Packet-granular round-robin merge of N_SRC AXI4-Stream sources into the XDMA C2H
// stream with a maximum packet length. Define C2H_ARB_SKID_EN to register m_axis.
module c2h_stream_arbiter
    import c2h_stream_arbiter_pkg::*;
#(
    parameter int N_SRC         = 2,
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int MAX_PKT_WORDS = C2H_MAX_PKT_WORDS
) (
    input  logic                        user_clk,
    input  logic                        user_rstn,
    input  logic                        dma_ena,
    input  logic [N_SRC-1:0]            src_mask,
    input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_SRC*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [N_SRC-1:0]            s_axis_tvalid,
    input  logic [N_SRC-1:0]            s_axis_tlast,
    output logic [N_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [N_SRC-1:0]            grant,
    output logic                        pkt_len_err
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int BCW   = beat_cnt_width(MAX_PKT_WORDS);
    localparam logic [BCW-1:0]   LAST_BEAT = BCW'(MAX_PKT_WORDS - 1);
    localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(N_SRC - 1);

    arb_state_e        state_q, state_d;
    logic [N_SRC-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]  last_ptr_q, last_ptr_d;
    logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
    logic              pkt_len_err_q, pkt_len_err_d;

    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [KEEP_WIDTH-1:0] sel_keep_s;
    logic                  sel_valid_s, sel_last_s;
    logic                  xfer_s, forced_last_s, out_valid_s, out_last_s;
    logic                  accept_ready_s, src_hs_s;
    logic [N_SRC-1:0]      req_s;
    logic [PTR_W-1:0]      pick_s;

    // First requester strictly after the previous winner, wrapping around.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                                 input logic [PTR_W-1:0] last);
        logic [PTR_W-1:0] pick;
        logic [PTR_W-1:0] idx;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int off = 1; off <= N_SRC; off++) begin
            idx = PTR_W'((int'(last) + off) % N_SRC);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Grant-selected source mux; all-zero when nothing is granted.
    always_comb begin
        sel_data_s  = '0;
        sel_keep_s  = '0;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            sel_data_s  = sel_data_s | (s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
            sel_keep_s  = sel_keep_s | (s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] & {KEEP_WIDTH{grant_q[i]}});
            sel_valid_s = sel_valid_s | (s_axis_tvalid[i] & grant_q[i]);
            sel_last_s  = sel_last_s | (s_axis_tlast[i] & grant_q[i]);
        end
    end

    assign xfer_s        = (state_q == ST_XFER);
    assign forced_last_s = xfer_s & (beat_cnt_q == LAST_BEAT);
    assign out_valid_s   = xfer_s & sel_valid_s;
    assign out_last_s    = xfer_s & (sel_last_s | forced_last_s);
    assign src_hs_s      = out_valid_s & accept_ready_s;
    assign s_axis_tready = grant_q & {N_SRC{xfer_s & accept_ready_s}};
    assign req_s         = s_axis_tvalid & src_mask;
    assign pick_s        = rr_pick(req_s, last_ptr_q);
    assign grant         = grant_q;
    assign pkt_len_err   = pkt_len_err_q;

`ifdef C2H_ARB_SKID_EN
    axis_skid_buffer #(
        .WIDTH (DATA_WIDTH + KEEP_WIDTH + 1)
    ) u_skid (
        .clk       (user_clk),
        .rstn      (user_rstn),
        .in_data   ({sel_data_s, sel_keep_s, out_last_s}),
        .in_valid  (out_valid_s),
        .in_ready  (accept_ready_s),
        .out_data  ({m_axis_tdata, m_axis_tkeep, m_axis_tlast}),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );
`else
    assign accept_ready_s = m_axis_tready;
    assign m_axis_tdata   = sel_data_s;
    assign m_axis_tkeep   = sel_keep_s;
    assign m_axis_tvalid  = out_valid_s;
    assign m_axis_tlast   = out_last_s;
`endif

    // Arbitration FSM next-state logic.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_ptr_d    = last_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        pkt_len_err_d = pkt_len_err_q;
        case (state_q)
            ST_IDLE: begin
                if (dma_ena) begin
                    state_d = ST_ARB;
                end else begin
                    pkt_len_err_d = 1'b0;
                end
            end
            ST_ARB: begin
                if (|req_s) begin
                    grant_d    = N_SRC'(1'b1) << pick_s;
                    last_ptr_d = pick_s;
                    beat_cnt_d = '0;
                    state_d    = ST_XFER;
                end else if (!dma_ena) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_XFER: begin
                if (src_hs_s && (sel_last_s || forced_last_s)) begin
                    // Overlength only when the cut did not coincide with the source's own tlast.
                    pkt_len_err_d = pkt_len_err_q | (forced_last_s & ~sel_last_s);
                    grant_d       = '0;
                    beat_cnt_d    = '0;
                    state_d       = dma_ena ? ST_ARB : ST_IDLE;
                end else if (src_hs_s) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // FSM and control registers with synchronous active-low reset.
    always_ff @(posedge user_clk) begin
        if (!user_rstn) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_ptr_q    <= PTR_RST;
            beat_cnt_q    <= '0;
            pkt_len_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_ptr_q    <= last_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            pkt_len_err_q <= pkt_len_err_d;
        end
    end

endmodule
